// File: rtl/obuf_pingpong_acc.sv
// obuf_pingpong_acc: ping-pong output buffer. The array writes/accumulates rows into
// the active bank while the other bank drains to memory as MEM_DATA_WIDTH beats.
// Build macro: OBUF_ACC_SAT_EN selects saturating accumulate (default: wrapping).
module obuf_pingpong_acc #(
   parameter int unsigned TAG_W          = 2,
   parameter int unsigned ARRAY_M        = 4,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned MEM_DATA_WIDTH = 64,
   parameter int unsigned BUF_ADDR_WIDTH = 10
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          buf_write_req,
   input  logic [BUF_ADDR_WIDTH-1:0]     buf_write_addr,
   input  logic [ARRAY_M*DATA_WIDTH-1:0] buf_write_data,
   input  logic                          buf_write_acc,
   input  logic                          swap_req,
   output logic                          swap_ack,
   input  logic [BUF_ADDR_WIDTH:0]       drain_rows,
   output logic                          mem_out_valid,
   input  logic                          mem_out_ready,
   output logic [MEM_DATA_WIDTH-1:0]     mem_out_data,
   output logic                          mem_out_last,
   output logic                          drain_busy,
   output logic                          active_bank
);
   localparam int unsigned GROUP_SIZE = MEM_DATA_WIDTH / DATA_WIDTH;
   localparam int unsigned NBEAT      = ARRAY_M / GROUP_SIZE;
   localparam int unsigned ROW_W      = ARRAY_M * DATA_WIDTH;
   localparam int unsigned ROW_AW     = BUF_ADDR_WIDTH - TAG_W;
   localparam int unsigned SUB_N      = 2 ** TAG_W;
   localparam int unsigned SUB_DEPTH  = 2 ** ROW_AW;
   localparam int unsigned BEAT_W     = (NBEAT > 1) ? $clog2(NBEAT) : 1;
   localparam int unsigned CNT_W      = BUF_ADDR_WIDTH + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} state_t;

   // Storage: [bank][sub-bank = low TAG_W address bits][row within sub-bank]
   logic [ROW_W-1:0] mem_q [2][SUB_N][SUB_DEPTH];

   // Write pipeline stage 1 registers
   logic                      s1_vld_q;
   logic                      s1_bank_q;
   logic                      s1_acc_q;
   logic [BUF_ADDR_WIDTH-1:0] s1_addr_q;
   logic [ROW_W-1:0]          s1_data_q;
   logic [ROW_W-1:0]          s1_old_q;
   logic [ROW_W-1:0]          s1_wdata_c;
   logic [ROW_W-1:0]          s0_rd_c;
   logic                      fwd_c;

   // Drain state
   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          rows_q, rows_d;
   logic [CNT_W-1:0]          rd_ptr_q, rd_ptr_d;
   logic [ROW_W-1:0]          cur_row_q, cur_row_d, nxt_row_q, nxt_row_d;
   logic                      cur_vld_q, cur_vld_d, nxt_vld_q, nxt_vld_d;
   logic                      cur_last_q, cur_last_d, nxt_last_q, nxt_last_d;
   logic [BEAT_W-1:0]         beat_q, beat_d;
   logic                      bank_d;
   logic [MEM_DATA_WIDTH-1:0] out_data_d;
   logic                      out_last_d;
   logic                      pop_beat_c, row_done_c, rd_issue_c;
   logic [ROW_W-1:0]          drain_rd_c;

   // Per-lane add: wrapping by default, signed saturation when enabled
   function automatic logic [DATA_WIDTH-1:0] lane_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
`ifdef OBUF_ACC_SAT_EN
      logic [DATA_WIDTH:0] sum;
      sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
      if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
         lane_add = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else
         lane_add = sum[DATA_WIDTH-1:0];
`else
      lane_add = a + b;
`endif
   endfunction

   // Stage-1 result: overwrite or lane-wise accumulate onto the stored row
   always_comb begin
      s1_wdata_c = s1_data_q;
      if (s1_acc_q) begin
         for (int m = 0; m < ARRAY_M; m++) begin
            s1_wdata_c[m*DATA_WIDTH +: DATA_WIDTH] =
               lane_add(s1_old_q[m*DATA_WIDTH +: DATA_WIDTH], s1_data_q[m*DATA_WIDTH +: DATA_WIDTH]);
         end
      end
   end

   // Stage-0 read with forwarding of the row stage 1 is writing this cycle
   assign fwd_c   = s1_vld_q && (s1_bank_q == active_bank) && (s1_addr_q == buf_write_addr);
   assign s0_rd_c = fwd_c ? s1_wdata_c
                          : mem_q[active_bank][buf_write_addr[TAG_W-1:0]][buf_write_addr[BUF_ADDR_WIDTH-1:TAG_W]];

   // Drain read always targets the bank that is not receiving array writes
   assign drain_rd_c = mem_q[~active_bank][rd_ptr_q[TAG_W-1:0]][rd_ptr_q[BUF_ADDR_WIDTH-1:TAG_W]];

   // Stage-0 -> stage-1 capture; bank tag travels with the write
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld_q  <= 1'b0;
         s1_bank_q <= 1'b0;
         s1_acc_q  <= 1'b0;
         s1_addr_q <= '0;
         s1_data_q <= '0;
         s1_old_q  <= '0;
      end else begin
         s1_vld_q <= buf_write_req;
         if (buf_write_req) begin
            s1_bank_q <= active_bank;
            s1_acc_q  <= buf_write_acc;
            s1_addr_q <= buf_write_addr;
            s1_data_q <= buf_write_data;
            s1_old_q  <= s0_rd_c;
         end
      end
   end

   // Stage-1 row write into storage
   always_ff @(posedge clk) begin
      if (s1_vld_q)
         mem_q[s1_bank_q][s1_addr_q[TAG_W-1:0]][s1_addr_q[BUF_ADDR_WIDTH-1:TAG_W]] <= s1_wdata_c;
   end

   // Drain FSM next-state: swap handling, two-row prefetch queue, beat sequencing
   always_comb begin
      state_d    = state_q;
      rows_d     = rows_q;
      rd_ptr_d   = rd_ptr_q;
      cur_row_d  = cur_row_q;
      cur_vld_d  = cur_vld_q;
      cur_last_d = cur_last_q;
      nxt_row_d  = nxt_row_q;
      nxt_vld_d  = nxt_vld_q;
      nxt_last_d = nxt_last_q;
      beat_d     = beat_q;
      bank_d     = active_bank;
      swap_ack   = 1'b0;
      rd_issue_c = 1'b0;
      pop_beat_c = cur_vld_q && mem_out_ready;
      row_done_c = pop_beat_c && (beat_q == BEAT_W'(NBEAT - 1));
      out_data_d = '0;
      out_last_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (swap_req && !reset) begin
               swap_ack = 1'b1;
               bank_d   = ~active_bank;
               rows_d   = drain_rows;
               rd_ptr_d = '0;
               if (drain_rows != '0)
                  state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (pop_beat_c)
               beat_d = row_done_c ? '0 : beat_q + BEAT_W'(1);
            if (row_done_c) begin
               cur_row_d  = nxt_row_q;
               cur_vld_d  = nxt_vld_q;
               cur_last_d = nxt_last_q;
               nxt_vld_d  = 1'b0;
            end
            rd_issue_c = (rd_ptr_q != rows_q) && !(cur_vld_d && nxt_vld_d);
            if (rd_issue_c) begin
               rd_ptr_d = rd_ptr_q + CNT_W'(1);
               if (!cur_vld_d) begin
                  cur_row_d  = drain_rd_c;
                  cur_vld_d  = 1'b1;
                  cur_last_d = (rd_ptr_q == rows_q - CNT_W'(1));
               end else begin
                  nxt_row_d  = drain_rd_c;
                  nxt_vld_d  = 1'b1;
                  nxt_last_d = (rd_ptr_q == rows_q - CNT_W'(1));
               end
            end
            if (row_done_c && cur_last_q)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      for (int b = 0; b < NBEAT; b++) begin
         if (beat_d == BEAT_W'(b))
            out_data_d = cur_row_d[b*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
      end
      out_last_d = cur_last_d && (beat_d == BEAT_W'(NBEAT - 1));
   end

   // Drain state register and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         rows_q        <= '0;
         rd_ptr_q      <= '0;
         cur_row_q     <= '0;
         cur_vld_q     <= 1'b0;
         cur_last_q    <= 1'b0;
         nxt_row_q     <= '0;
         nxt_vld_q     <= 1'b0;
         nxt_last_q    <= 1'b0;
         beat_q        <= '0;
         active_bank   <= 1'b0;
         mem_out_valid <= 1'b0;
         mem_out_data  <= '0;
         mem_out_last  <= 1'b0;
         drain_busy    <= 1'b0;
      end else begin
         state_q       <= state_d;
         rows_q        <= rows_d;
         rd_ptr_q      <= rd_ptr_d;
         cur_row_q     <= cur_row_d;
         cur_vld_q     <= cur_vld_d;
         cur_last_q    <= cur_last_d;
         nxt_row_q     <= nxt_row_d;
         nxt_vld_q     <= nxt_vld_d;
         nxt_last_q    <= nxt_last_d;
         beat_q        <= beat_d;
         active_bank   <= bank_d;
         mem_out_valid <= cur_vld_d;
         mem_out_data  <= out_data_d;
         mem_out_last  <= out_last_d;
         drain_busy    <= (state_d != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_obuf_pingpong_acc.sv
// tb_obuf_pingpong_acc: directed and randomized checks of obuf_pingpong_acc against a
// bank/row/lane array model with an expected-beat queue.
module tb_obuf_pingpong_acc;
   localparam int unsigned AW    = 10;
   localparam int unsigned NROWS = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         buf_write_req;
   logic [AW-1:0] buf_write_addr;
   logic [127:0] buf_write_data;
   logic         buf_write_acc;
   logic         swap_req;
   logic         swap_ack;
   logic [AW:0]  drain_rows;
   logic         mem_out_valid;
   logic         mem_out_ready;
   logic [63:0]  mem_out_data;
   logic         mem_out_last;
   logic         drain_busy;
   logic         active_bank;

   obuf_pingpong_acc dut (
      .clk(clk), .reset(reset),
      .buf_write_req(buf_write_req), .buf_write_addr(buf_write_addr),
      .buf_write_data(buf_write_data), .buf_write_acc(buf_write_acc),
      .swap_req(swap_req), .swap_ack(swap_ack), .drain_rows(drain_rows),
      .mem_out_valid(mem_out_valid), .mem_out_ready(mem_out_ready),
      .mem_out_data(mem_out_data), .mem_out_last(mem_out_last),
      .drain_busy(drain_busy), .active_bank(active_bank)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [31:0] mdl [2][NROWS][4];
   logic [63:0] exp_data [$];
   logic        exp_last [$];
   logic [63:0] cap [$];
   logic        m_bank, m_busy;
   int          n_chk = 0, n_fail = 0;
   int          cyc = 0, ack_cyc = 0, beats_seen = 0, beats_exp = 0;
   int          rdy_mode = 0, pat_idx = 0;
   bit          lat_pending = 0, post_rst = 0, last_ack = 0;
   bit          prev_stall = 0;
   logic [63:0] prev_data;
   logic        prev_last;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
      longint s;
      s = longint'($signed(a)) + longint'($signed(b));
`ifdef OBUF_ACC_SAT_EN
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
      return s[31:0];
   endfunction

   // One clock cycle: sample/check at negedge, update model, return 1 after posedge
   task automatic step();
      logic exp_ack;
      logic [63:0] d;
      logic l;
      int rows;
      if (reset) mem_out_ready = 1'b0;
      else if (rdy_mode == 0) mem_out_ready = 1'b1;
      else if (rdy_mode == 1) begin
         mem_out_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
         pat_idx++;
      end else mem_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      cyc++;
      if (post_rst) begin
         chk("rst_valid", mem_out_valid, 0);
         chk("rst_last", mem_out_last, 0);
         chk("rst_data", mem_out_data, 0);
         post_rst = 0;
      end
      chk("active_bank", active_bank, m_bank);
      chk("drain_busy", drain_busy, m_busy);
      exp_ack = swap_req && !m_busy && !reset;
      chk("swap_ack", swap_ack, exp_ack);
      last_ack = swap_ack;
      if (prev_stall) begin
         chk("stall_valid", mem_out_valid, 1);
         chk("stall_data", mem_out_data, prev_data);
         chk("stall_last", mem_out_last, prev_last);
      end
      if (lat_pending && mem_out_valid) begin
         chk("first_valid_latency", 64'(cyc - ack_cyc), 3);
         lat_pending = 0;
      end
      if (reset) begin
         exp_data.delete();
         exp_last.delete();
         m_bank = 0;
         m_busy = 0;
         lat_pending = 0;
         prev_stall = 0;
         post_rst = 1;
      end else begin
         if (buf_write_req) begin
            for (int m = 0; m < 4; m++)
               mdl[m_bank][buf_write_addr][m] = buf_write_acc ?
                  ref_add(mdl[m_bank][buf_write_addr][m], buf_write_data[m*32 +: 32]) :
                  buf_write_data[m*32 +: 32];
         end
         if (mem_out_valid && mem_out_ready) begin
            cap.push_back(mem_out_data);
            if (exp_data.size() == 0) chk("beat_unexpected", 1, 0);
            else begin
               d = exp_data.pop_front();
               l = exp_last.pop_front();
               beats_seen++;
               chk("beat_data", mem_out_data, d);
               chk("beat_last", mem_out_last, l);
               if (l) begin
                  chk("beat_count", 64'(beats_seen), 64'(beats_exp));
                  m_busy = 0;
               end
            end
         end
         if (exp_ack) begin
            rows = int'(drain_rows);
            for (int r = 0; r < rows; r++)
               for (int b = 0; b < 2; b++) begin
                  exp_data.push_back({mdl[m_bank][r][2*b+1], mdl[m_bank][r][2*b]});
                  exp_last.push_back((r == rows - 1) && (b == 1));
               end
            m_bank = ~m_bank;
            if (rows != 0) begin
               m_busy = 1;
               lat_pending = 1;
               ack_cyc = cyc;
               beats_seen = 0;
               beats_exp = rows * 2;
            end
         end
         prev_stall = mem_out_valid && !mem_out_ready;
         prev_data = mem_out_data;
         prev_last = mem_out_last;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int addr, input logic [127:0] data, input logic acc);
      buf_write_req  = 1'b1;
      buf_write_addr = AW'(addr);
      buf_write_data = data;
      buf_write_acc  = acc;
      step();
      buf_write_req = 1'b0;
   endtask

   task automatic swap(input int rows);
      swap_req   = 1'b1;
      drain_rows = (AW + 1)'(rows);
      for (int i = 0; i < 400; i++) begin
         step();
         if (last_ack) break;
      end
      if (!last_ack) chk("swap_timeout", 1, 0);
      swap_req = 1'b0;
   endtask

   task automatic wait_drain();
      int i;
      for (i = 0; i < 3000; i++) begin
         if (!m_busy && exp_data.size() == 0) break;
         step();
      end
      if (i == 3000) chk("drain_timeout", 1, 0);
   endtask

   // Give every modelled row of both banks a known value
   task automatic init_banks();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < NROWS; r++)
            wr(r, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
         swap(0);
      end
   endtask

   initial begin
      reset = 1'b1;
      buf_write_req = 0; buf_write_addr = '0; buf_write_data = '0; buf_write_acc = 0;
      swap_req = 0; drain_rows = '0; mem_out_ready = 0;
      m_bank = 0; m_busy = 0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      post_rst = 1;
      init_banks();

      // Overwrite then drain one row
      wr(0, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
      cap.delete();
      swap(1);
      wait_drain();
      chk("tp1_nbeats", 64'(cap.size()), 2);
      if (cap.size() == 2) begin
         chk("tp1_beat0", cap[0], 64'h00000002_00000001);
         chk("tp1_beat1", cap[1], 64'h00000004_00000003);
      end

      // Back-to-back accumulate on one row
      wr(5, {4{32'd1}}, 1'b0);
      wr(5, {4{32'd2}}, 1'b1);
      wr(5, {4{32'd2}}, 1'b1);
      wr(5, {4{32'd2}}, 1'b1);
      cap.delete();
      swap(6);
      wait_drain();
      chk("tp2_nbeats", 64'(cap.size()), 12);
      if (cap.size() == 12) begin
         chk("tp2_row5_b0", cap[10], 64'h00000007_00000007);
         chk("tp2_row5_b1", cap[11], 64'h00000007_00000007);
      end

      // Backpressure with ready pattern 1,0,0,1
      rdy_mode = 1; pat_idx = 0;
      cap.delete();
      swap(4);
      wait_drain();
      chk("tp3_nbeats", 64'(cap.size()), 8);
      rdy_mode = 0;

      // Accumulate at the positive edge of the range
      wr(9, {4{32'h7FFFFFF0}}, 1'b0);
      wr(9, {4{32'h00000020}}, 1'b1);
      cap.delete();
      swap(10);
      wait_drain();
      if (cap.size() == 20) begin
`ifdef OBUF_ACC_SAT_EN
         chk("tp5_sat", cap[18], 64'h7FFFFFFF_7FFFFFFF);
`else
         chk("tp5_wrap", cap[18], 64'h80000010_80000010);
`endif
      end else chk("tp5_nbeats", 64'(cap.size()), 20);

      // Swap held through a 16-row drain while writing the new bank
      rdy_mode = 2;
      swap(16);
      swap_req = 1'b1;
      drain_rows = '0;
      last_ack = 0;
      for (int i = 0; i < 400 && !last_ack; i++) begin
         buf_write_req  = ($urandom_range(0, 1) == 1);
         buf_write_addr = AW'($urandom_range(0, NROWS - 1));
         buf_write_data = {$urandom, $urandom, $urandom, $urandom};
         buf_write_acc  = $urandom_range(0, 1);
         step();
      end
      if (!last_ack) chk("tp4_ack_timeout", 1, 0);
      swap_req = 1'b0;
      buf_write_req = 1'b0;
      wait_drain();
      swap(0);
      swap(NROWS);
      wait_drain();
      rdy_mode = 0;

      // Reset while beat 3 of 8 is presented
      cap.delete();
      swap(4);
      for (int i = 0; i < 50 && cap.size() < 2; i++) step();
      chk("tp6_pre_beats", 64'(cap.size()), 2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      init_banks();
      swap(3);
      wait_drain();

      // Randomized traffic
      rdy_mode = 2;
      for (int i = 0; i < 1500; i++) begin
         buf_write_req  = ($urandom_range(0, 9) < 6);
         buf_write_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3))
                                                     : AW'($urandom_range(0, NROWS - 1));
         buf_write_data = {$urandom, $urandom, $urandom, $urandom};
         buf_write_acc  = $urandom_range(0, 1);
         if (!swap_req && $urandom_range(0, 19) == 0) begin
            swap_req   = 1'b1;
            drain_rows = (AW + 1)'($urandom_range(0, NROWS));
         end
         step();
         if (last_ack) swap_req = 1'b0;
      end
      buf_write_req = 1'b0;
      if (swap_req) swap(int'(drain_rows));
      wait_drain();
      chk("end_queue_empty", 64'(exp_data.size()), 0);
      chk("end_busy", drain_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
